alu16_sequencer: RTL and testbench
==================================

ALU16_SEQUENCER -- requirements
Module: alu16_sequencer

Interface
REQ-001 SHALL expose the following ports; one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock, shared with the 8-bit ALU.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  a command is offered.
- cmd_ready  out  1  the sequencer can accept a command.
- cmd_op  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 ADD.
- cmd_a  in  16  operand A.
- cmd_b  in  16  operand B.
- alu_a  out  8  ALU operand A.
- alu_b  out  8  ALU operand B.
- alu_funsel  out  4  ALU function select.
- alu_out  in  8  ALU result; registered, valid one edge after issue.
- alu_flags  in  4  ALU flags: [0] Z, [1] C, [2] N, [3] O.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  16  16-bit result.
- res_flags  out  4  result flags: [0] Z, [1] C, [2] N, [3] O.

Function
REQ-002 SHALL use states IDLE, LO_ISS, LO_CAP, HI_ISS, HI_CAP, INC_ISS, INC_CAP and DONE.
REQ-003 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on a rising edge with cmd_valid&&cmd_ready.
REQ-004 SHALL latch cmd_op, cmd_a and cmd_b on acceptance; later changes on the cmd_* inputs have no effect on the operation in flight.
REQ-005 SHALL map ALU FunSel as: AND=0111, OR=1000, XOR=1010, ADD and increment=0100.
REQ-006 SHALL register alu_a, alu_b and alu_funsel, and hold them stable during each *_ISS cycle; outside *_ISS states they hold their last value.
REQ-007 In LO_ISS, SHALL drive alu_a=A[7:0] and alu_b=B[7:0]; in LO_CAP, SHALL capture alu_out as lo and alu_flags[1] as C0.
REQ-008 In HI_ISS, SHALL drive alu_a=A[15:8] and alu_b=B[15:8]; in HI_CAP, SHALL capture alu_out as hi and alu_flags[1] as C1.
REQ-009 After HI_CAP, SHALL go to INC_ISS if op==ADD and C0==1, otherwise to DONE.
REQ-010 In INC_ISS, SHALL drive alu_a=hi, alu_b=8'h01 and FunSel 0100; in INC_CAP, SHALL capture alu_out as hi and alu_flags[1] as C2, then go to DONE.
REQ-011 SHALL set res_data={hi,lo}.
REQ-012 SHALL compute Z as (res_data==0) and N as res_data[15] locally; ALU Z, N and O flags are ignored.
REQ-013 For ADD, SHALL set C = C1|C2 (C2=0 if no increment) and O = (A[15]==B[15]) && (res_data[15]!=A[15]).
REQ-014 For logic ops, SHALL set C=0 and O=0.
REQ-015 SHALL assert res_valid in DONE only, holding res_data and res_flags stable until res_ready=1; the handshake edge returns the FSM to IDLE.
REQ-016 SHALL NOT accept a command on the same edge as a result handshake.
REQ-017 Latency from the acceptance edge to res_valid high SHALL be 4 edges for logic ops and ADD with C0=0, and 6 edges for ADD with C0=1.
REQ-018 SHALL let res_ready high outside DONE have no effect.

Reset
REQ-019 rst_n=0 SHALL immediately force IDLE, cmd_ready=1, res_valid=0, res_data=0, res_flags=0, alu_a=0, alu_b=0 and alu_funsel=0000, irrespective of clk.
REQ-020 Reset mid-operation SHALL discard the in-flight command; no res_valid is produced for it after release.
REQ-021 After rst_n deasserts, a command SHALL be acceptable on the first rising edge.

Verification (bench includes a behavioural registered 8-bit ALU with 1-edge latency)
REQ-022 AND A=F0F0 B=0FF0 -> res_data=00F0, flags 0000, res_valid 4 edges after acceptance.
REQ-023 XOR A=AAAA B=AAAA -> res_data=0000, Z=1, C=N=O=0, 4 edges.
REQ-024 ADD A=00FF B=0001 -> increment path, res_data=0100, flags 0000, 6 edges; FunSel 0100 with alu_b=01 observed in INC_ISS.
REQ-025 ADD A=FFFF B=0001 -> res_data=0000, Z=1, C=1 (via C2), N=0, O=0; ADD A=7FFF B=0001 -> res_data=8000, N=1, O=1, C=0.
REQ-026 res_ready held low for 3 cycles in DONE -> res_valid, res_data and res_flags stable, cmd_ready=0, cmd_valid ignored; IDLE on the edge res_ready=1.
REQ-027 rst_n pulsed low during HI_CAP of an ADD -> outputs at reset values without a clock edge, no res_valid after release, next command AND 0001&0001 -> 0001.

Source files
------------

// File: rtl/alu16_sequencer.sv
// 16-bit AND/OR/XOR/ADD sequencer built on a shared registered 8-bit ALU.
// Low byte, then high byte, plus an optional high-byte increment when an ADD carries out of the low byte.
module alu16_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_funsel,
    input  logic [7:0]  alu_out,
    input  logic [3:0]  alu_flags,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [3:0]  res_flags
);

    typedef enum logic [2:0] {
        IDLE, LO_ISS, LO_CAP, HI_ISS, HI_CAP, INC_ISS, INC_CAP, DONE
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b11;

    state_t      r_state, w_next;
    logic [1:0]  r_op;
    logic [15:0] r_a, r_b;
    logic [7:0]  r_lo, r_hi;
    logic        r_c0, r_c1;
    logic [3:0]  r_flags;

    logic [3:0]  w_funsel;
    logic        w_is_add, w_inc;
    logic [15:0] w_res;
    logic        w_c1, w_c2;
    logic [3:0]  w_flags;

    always_comb begin
        w_funsel = 4'b0111;
        case (cmd_op)
            2'b00: w_funsel = 4'b0111;
            2'b01: w_funsel = 4'b1000;
            2'b10: w_funsel = 4'b1010;
            2'b11: w_funsel = 4'b0100;
            default: w_funsel = 4'b0111;
        endcase
    end

    assign w_is_add = (r_op == OP_ADD);
    assign w_inc    = w_is_add && r_c0;

    // Flags are formed from the byte arriving on alu_out, so they are ready the cycle DONE is entered.
    assign w_res   = {alu_out, r_lo};
    assign w_c1    = (r_state == HI_CAP) ? alu_flags[1] : r_c1;
    assign w_c2    = (r_state == INC_CAP) && alu_flags[1];
    assign w_flags = {w_is_add && (r_a[15] == r_b[15]) && (w_res[15] != r_a[15]),
                      w_res[15],
                      w_is_add && (w_c1 || w_c2),
                      (w_res == 16'h0000)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (cmd_valid) w_next = LO_ISS;
            LO_ISS:  w_next = LO_CAP;
            LO_CAP:  w_next = HI_ISS;
            HI_ISS:  w_next = HI_CAP;
            HI_CAP:  w_next = w_inc ? INC_ISS : DONE;
            INC_ISS: w_next = INC_CAP;
            INC_CAP: w_next = DONE;
            DONE:    if (res_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == IDLE);
        res_valid = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_lo       <= '0;
            r_hi       <= '0;
            r_c0       <= 1'b0;
            r_c1       <= 1'b0;
            r_flags    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_funsel <= '0;
        end else begin
            case (r_state)
                IDLE: if (cmd_valid) begin
                    r_op       <= cmd_op;
                    r_a        <= cmd_a;
                    r_b        <= cmd_b;
                    alu_a      <= cmd_a[7:0];
                    alu_b      <= cmd_b[7:0];
                    alu_funsel <= w_funsel;
                end
                LO_CAP: begin
                    r_lo  <= alu_out;
                    r_c0  <= alu_flags[1];
                    alu_a <= r_a[15:8];
                    alu_b <= r_b[15:8];
                end
                HI_CAP: begin
                    r_hi <= alu_out;
                    r_c1 <= alu_flags[1];
                    if (w_inc) begin
                        alu_a      <= alu_out;
                        alu_b      <= 8'h01;
                        alu_funsel <= 4'b0100;
                    end else begin
                        r_flags <= w_flags;
                    end
                end
                INC_CAP: begin
                    r_hi    <= alu_out;
                    r_flags <= w_flags;
                end
                default: ;
            endcase
        end
    end

    assign res_data  = {r_hi, r_lo};
    assign res_flags = r_flags;

endmodule

// File: tb/tb_alu16_sequencer.sv
// Directed bench for alu16_sequencer with a behavioural registered 8-bit ALU.
module tb_alu16_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_funsel;
    logic [7:0]  alu_out = '0;
    logic [3:0]  alu_flags = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic [3:0]  res_flags;

    int checks = 0;
    int failures = 0;

    alu16_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_funsel(alu_funsel),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags)
    );

    always #5 clk = ~clk;

    // Registered 8-bit ALU: result and flags appear one edge after the operands.
    always_ff @(posedge clk) begin
        logic [8:0] sum;
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        case (alu_funsel)
            4'b0111: begin alu_out <= alu_a & alu_b; alu_flags <= 4'b0000; end
            4'b1000: begin alu_out <= alu_a | alu_b; alu_flags <= 4'b0000; end
            4'b1010: begin alu_out <= alu_a ^ alu_b; alu_flags <= 4'b0000; end
            4'b0100: begin alu_out <= sum[7:0];      alu_flags <= {2'b00, sum[8], 1'b0}; end
            default: begin alu_out <= 8'hEE;         alu_flags <= 4'b1111; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one command, measure latency, optionally stall in DONE, then complete the handshake.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] exp_data,
                           input logic [3:0] exp_flags, input int exp_lat,
                           input logic inc_hi, input int hold, input logic rr_early);
        int lat;
        @(negedge clk);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        res_ready = rr_early;
        check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = ~op; cmd_a = ~a; cmd_b = 16'h5A5A;
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 4 && inc_hi) begin
                check({tag, "_inc_funsel"}, {28'd0, alu_funsel}, 32'h4);
                check({tag, "_inc_b"}, {24'd0, alu_b}, 32'h01);
                check({tag, "_inc_a"}, {24'd0, alu_a}, {24'd0, exp_data[15:8] - 8'h01});
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_data"}, {16'd0, res_data}, {16'd0, exp_data});
        check({tag, "_flags"}, {28'd0, res_flags}, {28'd0, exp_flags});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_op = 2'b01; cmd_a = 16'h1234; cmd_b = 16'h4321;
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, {31'd0, res_valid}, 32'd1);
            check({tag, "_hold_data"}, {16'd0, res_data}, {16'd0, exp_data});
            check({tag, "_hold_flags"}, {28'd0, res_flags}, {28'd0, exp_flags});
            check({tag, "_hold_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
        end
        if (!rr_early) begin
            @(negedge clk);
            res_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "_hs_valid"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_hs_idle"}, {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        res_ready = 1'b0; cmd_valid = 1'b0;
    endtask

    initial begin
        #12;
        check("reset_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_valid", {31'd0, res_valid}, 32'd0);
        check("reset_data", {16'd0, res_data}, 32'd0);
        check("reset_flags", {28'd0, res_flags}, 32'd0);
        check("reset_alu", {alu_a, alu_b, 12'd0, alu_funsel}, 32'd0);
        rst_n = 1'b1;

        run_cmd("and", 2'b00, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 4, 1'b0, 0, 1'b0);
        run_cmd("xor", 2'b10, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0001, 4, 1'b0, 0, 1'b1);
        run_cmd("or",  2'b01, 16'h1200, 16'h0034, 16'h1234, 4'b0000, 4, 1'b0, 3, 1'b0);
        run_cmd("add_inc", 2'b11, 16'h00FF, 16'h0001, 16'h0100, 4'b0000, 6, 1'b1, 0, 1'b0);
        run_cmd("add_wrap", 2'b11, 16'hFFFF, 16'h0001, 16'h0000, 4'b0011, 6, 1'b1, 0, 1'b0);
        run_cmd("add_ovf", 2'b11, 16'h7FFF, 16'h0001, 16'h8000, 4'b1100, 6, 1'b1, 0, 1'b0);
        run_cmd("add_noinc", 2'b11, 16'h8100, 16'h8200, 16'h0300, 4'b1010, 4, 1'b0, 0, 1'b0);

        // Reset during HI_CAP of an ADD: third edge after acceptance.
        @(negedge clk);
        cmd_op = 2'b11; cmd_a = 16'h12FF; cmd_b = 16'h0001; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_data", {16'd0, res_data}, 32'd0);
        check("rst_flags", {28'd0, res_flags}, 32'd0);
        check("rst_alu", {alu_a, alu_b, 12'd0, alu_funsel}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("rst_no_result", {31'd0, res_valid}, 32'd0);
        end
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        run_cmd("post_rst_and", 2'b00, 16'h0001, 16'h0001, 16'h0001, 4'b0000, 4, 1'b0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
